// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline main-control unit.
package pipe_ctrl_pkg;

    // Width of the ALUOp field in the control bundle; MSBs above bit 1 tie to 0.
    localparam int unsigned ALUOP_W = 2;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b0000000;

    typedef enum logic [1:0] {
        ALU_MEM = 2'b00,
        ALU_BR  = 2'b01,
        ALU_RI  = 2'b10,
        ALU_LUI = 2'b11
    } aluop_e;

    typedef struct packed {
        logic               alusrc;
        logic               memtoreg;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic [ALUOP_W-1:0] aluop;
        logic               branch;
        logic               jaltoreg;
        logic               jalr;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } halt_state_e;

    // Zero-extend an ALUOp code into the bundle field width.
    function automatic logic [ALUOP_W-1:0] aluop_bits(aluop_e op);
        return ALUOP_W'(op);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder producing the control bundle and operand usage.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0]   opcode_i,
    output ctrl_bundle_t ctrl_o,
    output logic         uses_rs1_o,
    output logic         uses_rs2_o,
    output logic         is_halt_o,
    output logic         illegal_o
);

    // Opcode -> control fields; anything unrecognised is flagged illegal.
    always_comb begin
        ctrl_o     = CTRL_BUBBLE;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        is_halt_o  = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_i)
            OP_R: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = aluop_bits(ALU_RI);
                uses_rs1_o      = 1'b1;
                uses_rs2_o      = 1'b1;
            end
            OP_I: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = aluop_bits(ALU_RI);
                uses_rs1_o      = 1'b1;
            end
            OP_LUI: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = aluop_bits(ALU_LUI);
            end
            OP_LW: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memread  = 1'b1;
                ctrl_o.aluop    = aluop_bits(ALU_MEM);
                uses_rs1_o      = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memwrite = 1'b1;
                ctrl_o.aluop    = aluop_bits(ALU_MEM);
                uses_rs1_o      = 1'b1;
                uses_rs2_o      = 1'b1;
            end
            OP_BR: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.aluop  = aluop_bits(ALU_BR);
                uses_rs1_o    = 1'b1;
                uses_rs2_o    = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.branch   = 1'b1;
                ctrl_o.jaltoreg = 1'b1;
                ctrl_o.aluop    = aluop_bits(ALU_MEM);
            end
            OP_JALR: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.branch   = 1'b1;
                ctrl_o.jaltoreg = 1'b1;
                ctrl_o.jalr     = 1'b1;
                ctrl_o.aluop    = aluop_bits(ALU_MEM);
                uses_rs1_o      = 1'b1;
            end
            OP_HALT: is_halt_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Main pipeline control: decode, load-use stall, ID/EX control register, HALT drain FSM.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    output ctrl_bundle_t      ex_ctrl_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              stall_o,
    output logic              illegal_o,
    output logic              halted_o
);

    localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);

    ctrl_bundle_t      dec_ctrl;
    logic              dec_uses_rs1, dec_uses_rs2, dec_is_halt, dec_illegal;

    ctrl_bundle_t      ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              illegal_q, illegal_d;
    halt_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              running, hazard, accept, halt_go;

    ctrl_decode u_decode (
        .opcode_i   (opcode_i),
        .ctrl_o     (dec_ctrl),
        .uses_rs1_o (dec_uses_rs1),
        .uses_rs2_o (dec_uses_rs2),
        .is_halt_o  (dec_is_halt),
        .illegal_o  (dec_illegal)
    );

    // Hazard detection, stall and the next ID/EX contents.
    always_comb begin
        running = (state_q == RUN);
        hazard  = id_valid_i && ex_ctrl_q.memread && (ex_rd_q != '0) &&
                  ((dec_uses_rs1 && (rs1_i == ex_rd_q)) ||
                   (dec_uses_rs2 && (rs2_i == ex_rd_q)));
        // Flush wins over a load-use stall; a draining/halted pipe stays frozen regardless.
        stall_o = !running || (hazard && !flush_i);
        accept  = running && id_valid_i && !flush_i && !hazard;
        halt_go = accept && dec_is_halt;

        ex_ctrl_d = CTRL_BUBBLE;
        ex_rd_d   = '0;
        if (accept && !dec_is_halt && !dec_illegal) begin
            ex_ctrl_d = dec_ctrl;
            ex_rd_d   = rd_i;
        end
        illegal_d = accept && dec_illegal;
    end

    // HALT drain state machine and countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (halt_go) begin
                    state_d = DRAIN;
                    cnt_d   = CntW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            HALTED: ;
            default: state_d = RUN;
        endcase
    end

    // ID/EX control register and FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl_q <= CTRL_BUBBLE;
            ex_rd_q   <= '0;
            illegal_q <= 1'b0;
            state_q   <= RUN;
            cnt_q     <= '0;
        end else begin
            ex_ctrl_q <= ex_ctrl_d;
            ex_rd_q   <= ex_rd_d;
            illegal_q <= illegal_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_ctrl_o = ex_ctrl_q;
    assign ex_rd_o   = ex_rd_q;
    assign illegal_o = illegal_q;
    assign halted_o  = (state_q == HALTED);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit against an instruction-class reference model.
module tb_pipe_ctrl_unit;
    import pipe_ctrl_pkg::*;

    localparam int DC = 3;

    // Instruction classes used by the reference model.
    localparam int K_R = 0, K_I = 1, K_LUI = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_JAL = 6,
                   K_JALR = 7, K_HALT = 8, K_ILL = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         id_valid = 1'b0;
    logic [6:0]   opcode = 7'd0;
    logic [4:0]   rs1 = '0, rs2 = '0, rd = '0;
    logic         flush = 1'b0;
    ctrl_bundle_t ex_ctrl;
    logic [4:0]   ex_rd;
    logic         stall, illegal, halted;

    pipe_ctrl_unit #(.REG_AW(5), .DRAIN_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid_i (id_valid),
        .opcode_i   (opcode),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .rd_i       (rd),
        .flush_i    (flush),
        .ex_ctrl_o  (ex_ctrl),
        .ex_rd_o    (ex_rd),
        .stall_o    (stall),
        .illegal_o  (illegal),
        .halted_o   (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         stall;
        ctrl_bundle_t ex;
        logic [4:0]   rd;
        logic         ill;
        logic         hlt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state.
    ctrl_bundle_t m_ex;
    logic [4:0]   m_rd;
    int           cyc;
    int           halt_edge;
    logic         m_last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic int classify(input logic [6:0] op);
        case (op)
            7'h33: return K_R;
            7'h13: return K_I;
            7'h37: return K_LUI;
            7'h03: return K_LW;
            7'h23: return K_SW;
            7'h63: return K_BR;
            7'h6f: return K_JAL;
            7'h67: return K_JALR;
            7'h00: return K_HALT;
            default: return K_ILL;
        endcase
    endfunction

    // Control table per class: {alusrc,memtoreg,regwrite,memread,memwrite,aluop,branch,jaltoreg,jalr}.
    function automatic ctrl_bundle_t want_ctrl(input int k);
        logic [9:0] b;
        case (k)
            K_R:    b = 10'b00100_10_000;
            K_I:    b = 10'b10100_10_000;
            K_LUI:  b = 10'b10100_11_000;
            K_LW:   b = 10'b11110_00_000;
            K_SW:   b = 10'b10001_00_000;
            K_BR:   b = 10'b00000_01_100;
            K_JAL:  b = 10'b00100_00_110;
            K_JALR: b = 10'b10100_00_111;
            default: b = 10'b0;
        endcase
        return ctrl_bundle_t'(b);
    endfunction

    function automatic bit reads_rs1(input int k);
        return k inside {K_R, K_I, K_LW, K_SW, K_BR, K_JALR};
    endfunction

    function automatic bit reads_rs2(input int k);
        return k inside {K_R, K_SW, K_BR};
    endfunction

    // Drive one ID-stage cycle and queue what the DUT must show for it.
    task automatic issue(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] d, input logic fl);
        exp_t e;
        int   k;
        bit   run, haz, acc;
        @(posedge clk);
        #2;
        id_valid = v; opcode = op; rs1 = r1; rs2 = r2; rd = d; flush = fl;
        k   = classify(op);
        run = !(halt_edge >= 0 && cyc > halt_edge);
        haz = v && m_ex.memread && (m_rd != 0) &&
              ((reads_rs1(k) && r1 == m_rd) || (reads_rs2(k) && r2 == m_rd));
        acc = run && v && !fl && !haz;
        e.stall = !run || (haz && !fl);
        e.ill   = acc && (k == K_ILL);
        if (acc && k != K_ILL && k != K_HALT) begin
            e.ex = want_ctrl(k);
            e.rd = d;
        end else begin
            e.ex = '0;
            e.rd = '0;
        end
        if (acc && k == K_HALT) halt_edge = cyc;
        e.hlt = (halt_edge >= 0) && (cyc >= halt_edge + DC);
        m_ex = e.ex;
        m_rd = e.rd;
        m_last_stall = e.stall;
        q.push_back(e);
        cyc++;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ex_ctrl"}, 32'(ex_ctrl), 32'd0);
        chk({tag, "_ex_rd"}, 32'(ex_rd), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        chk("sb_empty_before_reset", 32'(q.size()), 32'd0);
        q.delete();
        reset = 1'b1; id_valid = 1'b0; flush = 1'b0;
        #1;
        check_idle_outputs("reset_async");
        m_ex = '0; m_rd = '0; cyc = 0; halt_edge = -1; m_last_stall = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("reset_held");
        #1;
        reset = 1'b0;
    endtask

    // Monitor: stall is checked mid-cycle, registered outputs just after the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                mon_e = q[0];
                chk("stall", 32'(stall), 32'(mon_e.stall));
                @(posedge clk);
                #1;
                chk("ex_ctrl", 32'(ex_ctrl), 32'(mon_e.ex));
                chk("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
                chk("illegal", 32'(illegal), 32'(mon_e.ill));
                chk("halted", 32'(halted), 32'(mon_e.hlt));
                void'(q.pop_front());
            end
        end
    end

    logic [6:0] legal_ops [8];
    logic [6:0] bad_ops [4];

    initial begin
        logic [6:0] op;
        logic [4:0] r1, r2, d;
        logic       v;
        int         waited;
        legal_ops = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67};
        bad_ops   = '{7'h7f, 7'h0f, 7'h73, 7'h17};
        m_ex = '0; m_rd = '0; cyc = 0; halt_edge = -1; m_last_stall = 1'b0;
        op = 7'h13; r1 = '0; r2 = '0; d = '0; v = 1'b0;

        do_reset();

        // Load-use: LW x5 ; ADD x6,x5,x1 held for one stall cycle.
        issue(1, 7'h03, 5'd2, 5'd0, 5'd5, 0);
        issue(1, 7'h33, 5'd5, 5'd1, 5'd6, 0);
        issue(1, 7'h33, 5'd5, 5'd1, 5'd6, 0);
        // rd=0 exempt; LUI reads no sources.
        issue(1, 7'h03, 5'd2, 5'd0, 5'd0, 0);
        issue(1, 7'h33, 5'd0, 5'd0, 5'd6, 0);
        issue(1, 7'h03, 5'd2, 5'd0, 5'd5, 0);
        issue(1, 7'h37, 5'd5, 5'd5, 5'd5, 0);
        // Hazard coincident with flush.
        issue(1, 7'h03, 5'd2, 5'd0, 5'd5, 0);
        issue(1, 7'h33, 5'd5, 5'd5, 5'd7, 1);
        // Illegal opcode then JALR.
        issue(1, 7'h7f, 5'd1, 5'd1, 5'd3, 0);
        issue(1, 7'h67, 5'd2, 5'd0, 5'd1, 0);
        issue(0, 7'h00, 5'd0, 5'd0, 5'd0, 0);
        // HALT under flush is ignored, then HALT taken and reset mid-drain.
        issue(1, 7'h00, 5'd0, 5'd0, 5'd0, 1);
        issue(1, 7'h00, 5'd0, 5'd0, 5'd0, 0);
        issue(1, 7'h33, 5'd1, 5'd2, 5'd3, 0);
        issue(1, 7'h33, 5'd1, 5'd2, 5'd3, 0);
        do_reset();

        // Randomized traffic; a stalled instruction is re-presented as IF/ID would hold it.
        for (int i = 0; i < 400; i++) begin
            if (!m_last_stall) begin
                v  = ($urandom_range(0, 9) != 0);
                op = ($urandom_range(0, 9) == 0) ? bad_ops[$urandom_range(0, 3)]
                                                 : legal_ops[$urandom_range(0, 7)];
                r1 = 5'($urandom_range(0, 3));
                r2 = 5'($urandom_range(0, 3));
                d  = 5'($urandom_range(0, 3));
            end
            issue(v, op, r1, r2, d, ($urandom_range(0, 9) == 0));
        end

        // Full drain to HALTED; flush and traffic afterwards must not disturb it.
        issue(1, 7'h00, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < DC + 5; i++) begin
            issue(1, legal_ops[$urandom_range(0, 7)], 5'd1, 5'd2, 5'd3,
                  ($urandom_range(0, 2) == 0));
        end

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #3;
        chk("sb_drained_at_end", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
